// File: rtl/mem_bus_arbiter.sv
// Shares one SRAM-like bus between the IF fetch port and the MEM data port.
// Define ARB_ROUND_ROBIN_EN to alternate grants when both ports request.
module mem_bus_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  pipe_hold_i,
    input  logic                  flush_i,
    input  logic                  inst_ce_i,
    input  logic [ADDR_W-1:0]     inst_addr_i,
    output logic [DATA_W-1:0]     inst_rdata_o,
    output logic                  inst_stall_o,
    input  logic                  data_ce_i,
    input  logic                  data_we_i,
    input  logic [DATA_W/8-1:0]   data_sel_i,
    input  logic [ADDR_W-1:0]     data_addr_i,
    input  logic [DATA_W-1:0]     data_wdata_i,
    output logic [DATA_W-1:0]     data_rdata_o,
    output logic                  data_stall_o,
    output logic                  bus_req_o,
    output logic                  bus_wr_o,
    output logic [DATA_W/8-1:0]   bus_sel_o,
    output logic [ADDR_W-1:0]     bus_addr_o,
    output logic [DATA_W-1:0]     bus_wdata_o,
    input  logic                  bus_addr_ok_i,
    input  logic                  bus_data_ok_i,
    input  logic [DATA_W-1:0]     bus_rdata_i
);

    localparam int SEL_W = DATA_W / 8;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_REQ   = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_DRAIN = 2'd3;

    logic [1:0]        state_q, state_d;
    logic              owner_q, owner_d;
    logic              bus_wr_q, bus_wr_d;
    logic [SEL_W-1:0]  bus_sel_q, bus_sel_d;
    logic [ADDR_W-1:0] bus_addr_q, bus_addr_d;
    logic [DATA_W-1:0] bus_wdata_q, bus_wdata_d;
    logic [DATA_W-1:0] inst_rdata_q, inst_rdata_d;
    logic [DATA_W-1:0] data_rdata_q, data_rdata_d;
    logic              inst_done_q, inst_done_d;
    logic              data_done_q, data_done_d;

    logic inst_pend, data_pend;
    logic prio_data, grant, gnt_data;
    logic complete;

`ifdef ARB_ROUND_ROBIN_EN
    logic last_q, last_d;
`endif

    always_comb begin
        inst_pend = inst_ce_i & ~inst_done_q;
        data_pend = data_ce_i & ~data_done_q;
`ifdef ARB_ROUND_ROBIN_EN
        prio_data = ~last_q;
`else
        prio_data = 1'b1;
`endif
        gnt_data = data_pend & (prio_data | ~inst_pend);
        grant    = (state_q == S_IDLE) & ~flush_i & (inst_pend | data_pend);
    end

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        bus_wr_d    = bus_wr_q;
        bus_sel_d   = bus_sel_q;
        bus_addr_d  = bus_addr_q;
        bus_wdata_d = bus_wdata_q;
        complete    = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        last_d      = last_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (grant) begin
                    state_d = S_REQ;
                    owner_d = gnt_data;
`ifdef ARB_ROUND_ROBIN_EN
                    last_d  = gnt_data;
`endif
                    if (gnt_data) begin
                        bus_wr_d    = data_we_i;
                        bus_sel_d   = data_sel_i;
                        bus_addr_d  = data_addr_i;
                        bus_wdata_d = data_wdata_i;
                    end else begin
                        bus_wr_d   = 1'b0;
                        bus_sel_d  = '1;
                        bus_addr_d = inst_addr_i;
                    end
                end
            end
            S_REQ: begin
                if (bus_addr_ok_i) begin
                    // flush after acceptance still owes the slave a response
                    if (bus_data_ok_i) begin
                        state_d  = S_IDLE;
                        complete = ~flush_i;
                    end else begin
                        state_d = flush_i ? S_DRAIN : S_WAIT;
                    end
                end else if (flush_i) begin
                    state_d = S_IDLE;
                end
            end
            S_WAIT: begin
                if (bus_data_ok_i) begin
                    state_d  = S_IDLE;
                    complete = ~flush_i;
                end else if (flush_i) begin
                    state_d = S_DRAIN;
                end
            end
            default: begin
                if (bus_data_ok_i) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_comb begin
        inst_rdata_d = inst_rdata_q;
        data_rdata_d = data_rdata_q;
        inst_done_d  = inst_done_q;
        data_done_d  = data_done_q;
        if (complete & ~owner_q) begin
            inst_rdata_d = bus_rdata_i;
            inst_done_d  = 1'b1;
        end
        if (complete & owner_q) begin
            if (!bus_wr_q) begin
                data_rdata_d = bus_rdata_i;
            end
            data_done_d = 1'b1;
        end
        if (flush_i | (inst_done_q & ~pipe_hold_i)) begin
            inst_done_d = 1'b0;
        end
        if (flush_i | (data_done_q & ~pipe_hold_i)) begin
            data_done_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            owner_q      <= 1'b0;
            bus_wr_q     <= 1'b0;
            bus_sel_q    <= '0;
            bus_addr_q   <= '0;
            bus_wdata_q  <= '0;
            inst_rdata_q <= '0;
            data_rdata_q <= '0;
            inst_done_q  <= 1'b0;
            data_done_q  <= 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
            last_q       <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            bus_wr_q     <= bus_wr_d;
            bus_sel_q    <= bus_sel_d;
            bus_addr_q   <= bus_addr_d;
            bus_wdata_q  <= bus_wdata_d;
            inst_rdata_q <= inst_rdata_d;
            data_rdata_q <= data_rdata_d;
            inst_done_q  <= inst_done_d;
            data_done_q  <= data_done_d;
`ifdef ARB_ROUND_ROBIN_EN
            last_q       <= last_d;
`endif
        end
    end

    assign bus_req_o    = (state_q == S_REQ);
    assign bus_wr_o     = bus_wr_q;
    assign bus_sel_o    = bus_sel_q;
    assign bus_addr_o   = bus_addr_q;
    assign bus_wdata_o  = bus_wdata_q;
    assign inst_rdata_o = inst_rdata_q;
    assign data_rdata_o = data_rdata_q;
    assign inst_stall_o = inst_ce_i & ~inst_done_q;
    assign data_stall_o = data_ce_i & ~data_done_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed bench for mem_bus_arbiter; the bus slave is driven cycle by cycle.
// Honours ARB_ROUND_ROBIN_EN when picking the expected grant order.
module tb_mem_bus_arbiter;

    logic        clk;
    logic        rst;
    logic        pipe_hold_i;
    logic        flush_i;
    logic        inst_ce_i;
    logic [31:0] inst_addr_i;
    logic [31:0] inst_rdata_o;
    logic        inst_stall_o;
    logic        data_ce_i;
    logic        data_we_i;
    logic [3:0]  data_sel_i;
    logic [31:0] data_addr_i;
    logic [31:0] data_wdata_i;
    logic [31:0] data_rdata_o;
    logic        data_stall_o;
    logic        bus_req_o;
    logic        bus_wr_o;
    logic [3:0]  bus_sel_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic        bus_addr_ok_i;
    logic        bus_data_ok_i;
    logic [31:0] bus_rdata_i;

    int npass;
    int nfail;
    int ntot;

`ifdef ARB_ROUND_ROBIN_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif

    mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk          (clk),
        .rst          (rst),
        .pipe_hold_i  (pipe_hold_i),
        .flush_i      (flush_i),
        .inst_ce_i    (inst_ce_i),
        .inst_addr_i  (inst_addr_i),
        .inst_rdata_o (inst_rdata_o),
        .inst_stall_o (inst_stall_o),
        .data_ce_i    (data_ce_i),
        .data_we_i    (data_we_i),
        .data_sel_i   (data_sel_i),
        .data_addr_i  (data_addr_i),
        .data_wdata_i (data_wdata_i),
        .data_rdata_o (data_rdata_o),
        .data_stall_o (data_stall_o),
        .bus_req_o    (bus_req_o),
        .bus_wr_o     (bus_wr_o),
        .bus_sel_o    (bus_sel_o),
        .bus_addr_o   (bus_addr_o),
        .bus_wdata_o  (bus_wdata_o),
        .bus_addr_ok_i(bus_addr_ok_i),
        .bus_data_ok_i(bus_data_ok_i),
        .bus_rdata_i  (bus_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else begin
            nfail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    initial begin
        npass = 0;
        nfail = 0;
        ntot  = 0;
        rst = 1'b1;
        pipe_hold_i = 1'b0;
        flush_i = 1'b0;
        inst_ce_i = 1'b0;
        inst_addr_i = 32'h0;
        data_ce_i = 1'b0;
        data_we_i = 1'b0;
        data_sel_i = 4'h0;
        data_addr_i = 32'h0;
        data_wdata_i = 32'h0;
        bus_addr_ok_i = 1'b0;
        bus_data_ok_i = 1'b0;
        bus_rdata_i = 32'h0;

        // reset
        repeat (2) cyc();
        rst = 1'b0;
        #1;
        chk("rst_req", 32'(bus_req_o), 32'd0);
        chk("rst_wr", 32'(bus_wr_o), 32'd0);
        chk("rst_sel", 32'(bus_sel_o), 32'd0);
        chk("rst_addr", bus_addr_o, 32'h0);
        chk("rst_wdata", bus_wdata_o, 32'h0);
        chk("rst_irdata", inst_rdata_o, 32'h0);
        chk("rst_drdata", data_rdata_o, 32'h0);
        chk("rst_istall", 32'(inst_stall_o), 32'd0);
        chk("rst_dstall", 32'(data_stall_o), 32'd0);

        // 1: single fetch, addr_ok at 1, data_ok at 2
        cyc();
        inst_ce_i = 1'b1;
        inst_addr_i = 32'hBFC0_0000;
        #1;
        chk("t1_c0_stall", 32'(inst_stall_o), 32'd1);
        chk("t1_c0_req", 32'(bus_req_o), 32'd0);
        cyc();
        bus_addr_ok_i = 1'b1;
        #1;
        chk("t1_c1_req", 32'(bus_req_o), 32'd1);
        chk("t1_c1_addr", bus_addr_o, 32'hBFC0_0000);
        chk("t1_c1_wr", 32'(bus_wr_o), 32'd0);
        chk("t1_c1_sel", 32'(bus_sel_o), 32'hF);
        chk("t1_c1_stall", 32'(inst_stall_o), 32'd1);
        cyc();
        bus_addr_ok_i = 1'b0;
        bus_data_ok_i = 1'b1;
        bus_rdata_i = 32'h3C08_BFAF;
        #1;
        chk("t1_c2_req", 32'(bus_req_o), 32'd0);
        chk("t1_c2_stall", 32'(inst_stall_o), 32'd1);
        cyc();
        bus_data_ok_i = 1'b0;
        #1;
        chk("t1_c3_stall", 32'(inst_stall_o), 32'd0);
        chk("t1_c3_rdata", inst_rdata_o, 32'h3C08_BFAF);
        inst_ce_i = 1'b0;
        cyc();

        // 2: simultaneous fetch and load, data first
        cyc();
        inst_ce_i = 1'b1;
        inst_addr_i = 32'hBFC0_0004;
        data_ce_i = 1'b1;
        data_we_i = 1'b0;
        data_sel_i = 4'hF;
        data_addr_i = 32'h8000_0010;
        #1;
        chk("t2_c0_istall", 32'(inst_stall_o), 32'd1);
        chk("t2_c0_dstall", 32'(data_stall_o), 32'd1);
        cyc();
        bus_addr_ok_i = 1'b1;
        bus_data_ok_i = 1'b1;
        bus_rdata_i = 32'h1111_2222;
        #1;
        chk("t2_c1_req", 32'(bus_req_o), 32'd1);
        chk("t2_c1_addr", bus_addr_o, 32'h8000_0010);
        chk("t2_c1_wr", 32'(bus_wr_o), 32'd0);
        cyc();
        bus_addr_ok_i = 1'b0;
        bus_data_ok_i = 1'b0;
        #1;
        chk("t2_c2_dstall", 32'(data_stall_o), 32'd0);
        chk("t2_c2_drdata", data_rdata_o, 32'h1111_2222);
        chk("t2_c2_istall", 32'(inst_stall_o), 32'd1);
        chk("t2_c2_req", 32'(bus_req_o), 32'd0);
        data_ce_i = 1'b0;
        cyc();
        bus_addr_ok_i = 1'b1;
        bus_data_ok_i = 1'b1;
        bus_rdata_i = 32'h2222_3333;
        #1;
        chk("t2_c3_req", 32'(bus_req_o), 32'd1);
        chk("t2_c3_addr", bus_addr_o, 32'hBFC0_0004);
        chk("t2_c3_wr", 32'(bus_wr_o), 32'd0);
        chk("t2_c3_istall", 32'(inst_stall_o), 32'd1);
        cyc();
        bus_addr_ok_i = 1'b0;
        bus_data_ok_i = 1'b0;
        #1;
        chk("t2_c4_istall", 32'(inst_stall_o), 32'd0);
        chk("t2_c4_irdata", inst_rdata_o, 32'h2222_3333);
        chk("t2_c4_drdata", data_rdata_o, 32'h1111_2222);
        inst_ce_i = 1'b0;
        cyc();

        // 3: store with addr_ok held off for 5 cycles
        cyc();
        data_ce_i = 1'b1;
        data_we_i = 1'b1;
        data_sel_i = 4'hF;
        data_addr_i = 32'h8000_0020;
        data_wdata_i = 32'hDEAD_BEEF;
        #1;
        chk("t3_c0_dstall", 32'(data_stall_o), 32'd1);
        for (int i = 0; i < 5; i++) begin
            cyc();
            data_addr_i = 32'h0;
            data_wdata_i = 32'h0;
            data_sel_i = 4'h0;
            #1;
            chk("t3_hold_req", 32'(bus_req_o), 32'd1);
            chk("t3_hold_addr", bus_addr_o, 32'h8000_0020);
            chk("t3_hold_wdata", bus_wdata_o, 32'hDEAD_BEEF);
            chk("t3_hold_wr", 32'(bus_wr_o), 32'd1);
            chk("t3_hold_sel", 32'(bus_sel_o), 32'hF);
        end
        cyc();
        bus_addr_ok_i = 1'b1;
        #1;
        chk("t3_ack_req", 32'(bus_req_o), 32'd1);
        chk("t3_ack_dstall", 32'(data_stall_o), 32'd1);
        cyc();
        bus_addr_ok_i = 1'b0;
        bus_data_ok_i = 1'b1;
        bus_rdata_i = 32'hAAAA_AAAA;
        #1;
        chk("t3_dok_req", 32'(bus_req_o), 32'd0);
        chk("t3_dok_dstall", 32'(data_stall_o), 32'd1);
        cyc();
        bus_data_ok_i = 1'b0;
        #1;
        chk("t3_done_dstall", 32'(data_stall_o), 32'd0);
        chk("t3_done_drdata", data_rdata_o, 32'h1111_2222);
        data_ce_i = 1'b0;
        data_we_i = 1'b0;
        cyc();

        // 4: flush in WAIT drains the response
        cyc();
        inst_ce_i = 1'b1;
        inst_addr_i = 32'hBFC0_0008;
        #1;
        chk("t4_c0_stall", 32'(inst_stall_o), 32'd1);
        cyc();
        bus_addr_ok_i = 1'b1;
        #1;
        chk("t4_c1_req", 32'(bus_req_o), 32'd1);
        chk("t4_c1_addr", bus_addr_o, 32'hBFC0_0008);
        cyc();
        bus_addr_ok_i = 1'b0;
        flush_i = 1'b1;
        inst_addr_i = 32'hBFC0_0380;
        #1;
        chk("t4_c2_req", 32'(bus_req_o), 32'd0);
        chk("t4_c2_stall", 32'(inst_stall_o), 32'd1);
        cyc();
        flush_i = 1'b0;
        bus_data_ok_i = 1'b1;
        bus_rdata_i = 32'h1234_5678;
        #1;
        chk("t4_drain_req", 32'(bus_req_o), 32'd0);
        chk("t4_drain_stall", 32'(inst_stall_o), 32'd1);
        cyc();
        bus_data_ok_i = 1'b0;
        #1;
        chk("t4_idle_irdata", inst_rdata_o, 32'h2222_3333);
        chk("t4_idle_stall", 32'(inst_stall_o), 32'd1);
        chk("t4_idle_req", 32'(bus_req_o), 32'd0);
        cyc();
        bus_addr_ok_i = 1'b1;
        bus_data_ok_i = 1'b1;
        bus_rdata_i = 32'h5555_6666;
        #1;
        chk("t4_refetch_req", 32'(bus_req_o), 32'd1);
        chk("t4_refetch_addr", bus_addr_o, 32'hBFC0_0380);

        // 5: done held by pipe_hold
        cyc();
        bus_addr_ok_i = 1'b0;
        bus_data_ok_i = 1'b0;
        pipe_hold_i = 1'b1;
        #1;
        chk("t5_h0_stall", 32'(inst_stall_o), 32'd0);
        chk("t5_h0_rdata", inst_rdata_o, 32'h5555_6666);
        for (int i = 0; i < 2; i++) begin
            cyc();
            #1;
            chk("t5_hold_stall", 32'(inst_stall_o), 32'd0);
            chk("t5_hold_rdata", inst_rdata_o, 32'h5555_6666);
            chk("t5_hold_req", 32'(bus_req_o), 32'd0);
        end
        cyc();
        pipe_hold_i = 1'b0;
        #1;
        chk("t5_rel_stall", 32'(inst_stall_o), 32'd0);
        cyc();
        #1;
        chk("t5_clr_stall", 32'(inst_stall_o), 32'd1);
        inst_ce_i = 1'b0;
        cyc();

        // 6: reset in REQ
        cyc();
        data_ce_i = 1'b1;
        data_we_i = 1'b0;
        data_sel_i = 4'hF;
        data_addr_i = 32'h8000_0040;
        #1;
        cyc();
        #1;
        chk("t6_req", 32'(bus_req_o), 32'd1);
        chk("t6_addr", bus_addr_o, 32'h8000_0040);
        rst = 1'b1;
        cyc();
        #1;
        chk("t6_rst_req", 32'(bus_req_o), 32'd0);
        chk("t6_rst_addr", bus_addr_o, 32'h0);
        chk("t6_rst_irdata", inst_rdata_o, 32'h0);
        rst = 1'b0;
        data_ce_i = 1'b0;
        cyc();

        // grant order with both ports pending after a data grant
        cyc();
        inst_ce_i = 1'b1;
        inst_addr_i = 32'hBFC0_0010;
        data_ce_i = 1'b1;
        data_addr_i = 32'h8000_0050;
        #1;
        chk("ord_c0_istall", 32'(inst_stall_o), 32'd1);
        chk("ord_c0_dstall", 32'(data_stall_o), 32'd1);
        cyc();
        bus_addr_ok_i = 1'b1;
        bus_data_ok_i = 1'b1;
        bus_rdata_i = 32'h0101_0101;
        #1;
        chk("ord_g1_addr", bus_addr_o, 32'h8000_0050);
        cyc();
        bus_addr_ok_i = 1'b0;
        bus_data_ok_i = 1'b0;
        #1;
        chk("ord_g1_dstall", 32'(data_stall_o), 32'd0);
        chk("ord_g1_drdata", data_rdata_o, 32'h0101_0101);
        flush_i = 1'b1;
        cyc();
        flush_i = 1'b0;
        #1;
        chk("ord_fl_req", 32'(bus_req_o), 32'd0);
        chk("ord_fl_dstall", 32'(data_stall_o), 32'd1);
        chk("ord_fl_istall", 32'(inst_stall_o), 32'd1);
        cyc();
        bus_addr_ok_i = 1'b1;
        bus_data_ok_i = 1'b1;
        bus_rdata_i = 32'h0202_0202;
        #1;
        chk("ord_g2_addr", bus_addr_o, RR ? 32'hBFC0_0010 : 32'h8000_0050);
        cyc();
        bus_addr_ok_i = 1'b0;
        bus_data_ok_i = 1'b0;
        #1;
        chk("ord_g2_wstall", 32'(RR ? inst_stall_o : data_stall_o), 32'd0);
        chk("ord_g2_lstall", 32'(RR ? data_stall_o : inst_stall_o), 32'd1);
        cyc();
        bus_addr_ok_i = 1'b1;
        bus_data_ok_i = 1'b1;
        bus_rdata_i = 32'h0303_0303;
        #1;
        chk("ord_g3_addr", bus_addr_o, RR ? 32'h8000_0050 : 32'hBFC0_0010);
        cyc();
        bus_addr_ok_i = 1'b0;
        bus_data_ok_i = 1'b0;
        #1;
        chk("ord_g3_irdata", inst_rdata_o, RR ? 32'h0202_0202 : 32'h0303_0303);
        chk("ord_g3_drdata", data_rdata_o, RR ? 32'h0303_0303 : 32'h0202_0202);
        inst_ce_i = 1'b0;
        data_ce_i = 1'b0;
        cyc();

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
